// File: rtl/trap_cause_unit.sv
// trap_cause_unit
//   Registered trap arbiter between the pipeline exception/interrupt flags and the
//   CSR unit. In IDLE it resolves pending interrupts and synchronous exceptions into
//   one cause, captures EPC and TVAL, and offers the record with a valid/ready
//   handshake. After acceptance it holds flush_o for FLUSH_CYCLES cycles. It ignores
//   all event inputs outside IDLE.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | watching the commit boundary for an interrupt or exception
//   S_REQ   | trap record valid, waiting for trap_ready_i
//   S_FLUSH | flush_o high, down-counter running to terminal count 0
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   instr_valid_i                   instruction present at the commit boundary
//   exc_i[15:0], break_src_i[2:0]   exception flags (index == code), breakpoint source
//   irq_i, irq_en_i, irq_gie_i      pending lines, per-line and global enables
//   pc_i, instr_i, mem_addr_i       trap value / EPC sources
//   trap_valid_o, trap_ready_i      handshake to the CSR unit
//   trap_cause_o, trap_tval_o, trap_epc_o   captured trap record
//   flush_o, busy_o                 pipeline flush request, boundary stall
module trap_cause_unit #(
    parameter int XLEN         = 32,
    parameter int NUM_IRQ      = 16,
    parameter int CAUSE_W      = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid_i,
    input  logic [15:0]        exc_i,
    input  logic [2:0]         break_src_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               irq_gie_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [31:0]        instr_i,
    input  logic [XLEN-1:0]    mem_addr_i,
    output logic               trap_valid_o,
    input  logic               trap_ready_i,
    output logic [XLEN-1:0]    trap_cause_o,
    output logic [XLEN-1:0]    trap_tval_o,
    output logic [XLEN-1:0]    trap_epc_o,
    output logic               flush_o,
    output logic               busy_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FLUSH} state_e;
    typedef enum logic [1:0] {TV_PC, TV_INSTR, TV_MEM, TV_ZERO} tval_sel_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    cause_q, cause_d;
    logic [XLEN-1:0]    tval_q, tval_d;
    logic [XLEN-1:0]    epc_q, epc_d;

    logic [NUM_IRQ-1:0] act;
    logic               irq_hit;
    logic [CAUSE_W-1:0] irq_code;
    logic               exc_hit;
    logic [CAUSE_W-1:0] exc_code;
    tval_sel_e          tval_sel;

    // Codes 10 and 14 are reserved and never produce a trap.
    logic unused_exc;
    assign unused_exc = exc_i[14] ^ exc_i[10];

    assign act = irq_i & irq_en_i & {NUM_IRQ{irq_gie_i}};

    // Later assignments override earlier ones, so the platform lines are scanned
    // upward (highest index wins) and the standard codes are applied lowest
    // priority first, ending with 11.
    always_comb begin
        irq_hit  = 1'b0;
        irq_code = '0;
        for (int i = 12; i < NUM_IRQ; i++) begin
            if (act[i]) begin
                irq_hit  = 1'b1;
                irq_code = CAUSE_W'(i);
            end
        end
        if (act[5])  begin irq_hit = 1'b1; irq_code = CAUSE_W'(5);  end
        if (act[1])  begin irq_hit = 1'b1; irq_code = CAUSE_W'(1);  end
        if (act[9])  begin irq_hit = 1'b1; irq_code = CAUSE_W'(9);  end
        if (act[7])  begin irq_hit = 1'b1; irq_code = CAUSE_W'(7);  end
        if (act[3])  begin irq_hit = 1'b1; irq_code = CAUSE_W'(3);  end
        if (act[11]) begin irq_hit = 1'b1; irq_code = CAUSE_W'(11); end
    end

    // Instruction-stage faults, then environment calls/breakpoints, then memory
    // stage. Code 3 is only an exception when some breakpoint source is set.
    always_comb begin
        exc_hit  = 1'b1;
        exc_code = '0;
        tval_sel = TV_ZERO;
        if (exc_i[3] && break_src_i[0]) begin exc_code = CAUSE_W'(3);  tval_sel = TV_PC;    end
        else if (exc_i[12])             begin exc_code = CAUSE_W'(12); tval_sel = TV_PC;    end
        else if (exc_i[1])              begin exc_code = CAUSE_W'(1);  tval_sel = TV_PC;    end
        else if (exc_i[2])              begin exc_code = CAUSE_W'(2);  tval_sel = TV_INSTR; end
        else if (exc_i[0])              begin exc_code = CAUSE_W'(0);  tval_sel = TV_PC;    end
        else if (exc_i[8])              begin exc_code = CAUSE_W'(8);  tval_sel = TV_ZERO;  end
        else if (exc_i[9])              begin exc_code = CAUSE_W'(9);  tval_sel = TV_ZERO;  end
        else if (exc_i[11])             begin exc_code = CAUSE_W'(11); tval_sel = TV_ZERO;  end
        else if (exc_i[3] && break_src_i[2]) begin exc_code = CAUSE_W'(3); tval_sel = TV_PC;  end
        else if (exc_i[3] && break_src_i[1]) begin exc_code = CAUSE_W'(3); tval_sel = TV_MEM; end
        else if (exc_i[4])              begin exc_code = CAUSE_W'(4);  tval_sel = TV_MEM;   end
        else if (exc_i[6])              begin exc_code = CAUSE_W'(6);  tval_sel = TV_MEM;   end
        else if (exc_i[13])             begin exc_code = CAUSE_W'(13); tval_sel = TV_MEM;   end
        else if (exc_i[15])             begin exc_code = CAUSE_W'(15); tval_sel = TV_MEM;   end
        else if (exc_i[5])              begin exc_code = CAUSE_W'(5);  tval_sel = TV_MEM;   end
        else if (exc_i[7])              begin exc_code = CAUSE_W'(7);  tval_sel = TV_MEM;   end
        else                            begin exc_hit = 1'b0; end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        epc_d   = epc_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid_i && (irq_hit || exc_hit)) begin
                    state_d = S_REQ;
                    epc_d   = pc_i;
                    cause_d = '0;
                    if (irq_hit) begin
                        cause_d[XLEN-1]      = 1'b1;
                        cause_d[CAUSE_W-1:0] = irq_code;
                        tval_d               = '0;
                    end else begin
                        cause_d[CAUSE_W-1:0] = exc_code;
                        case (tval_sel)
                            TV_PC:    tval_d = pc_i;
                            TV_INSTR: tval_d = XLEN'(instr_i);
                            TV_MEM:   tval_d = mem_addr_i;
                            default:  tval_d = '0;
                        endcase
                    end
                end
            end
            S_REQ: begin
                if (trap_ready_i) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            epc_q   <= epc_d;
        end
    end

    assign trap_valid_o = (state_q == S_REQ);
    assign flush_o      = (state_q == S_FLUSH);
    assign busy_o       = (state_q != S_IDLE);
    assign trap_cause_o = cause_q;
    assign trap_tval_o  = tval_q;
    assign trap_epc_o   = epc_q;

endmodule

// File: tb/tb_trap_cause_unit.sv
module tb_trap_cause_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] exc;
    logic [2:0]  bs;
    logic [15:0] irq, irq_en;
    logic        gie;
    logic [31:0] pc, instr, mem_addr;
    logic        valid, ready;
    logic [31:0] cause, tval, epc;
    logic        flush, busy;

    int n_cmp = 0;
    int n_err = 0;

    trap_cause_unit #(.XLEN(32), .NUM_IRQ(16), .CAUSE_W(6), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .exc_i(exc),
        .break_src_i(bs), .irq_i(irq), .irq_en_i(irq_en), .irq_gie_i(gie),
        .pc_i(pc), .instr_i(instr), .mem_addr_i(mem_addr), .trap_valid_o(valid),
        .trap_ready_i(ready), .trap_cause_o(cause), .trap_tval_o(tval),
        .trap_epc_o(epc), .flush_o(flush), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Priority-table reference model of the resolution rules.
    function automatic void ref_model(
        input logic iv, input logic [15:0] e, input logic [2:0] b,
        input logic [15:0] ir, input logic [15:0] ie, input logic g,
        input logic [31:0] p, input logic [31:0] ins, input logic [31:0] ma,
        output bit hit, output logic [31:0] c, output logic [31:0] tv);
        int io[6]          = '{11, 3, 7, 9, 1, 5};
        int eb[16]         = '{3, 12, 1, 2, 0, 8, 9, 11, 3, 3, 4, 6, 13, 15, 5, 7};
        int bq[16]         = '{1, 0, 0, 0, 0, 0, 0, 0, 4, 2, 0, 0, 0, 0, 0, 0};
        int tk[16]         = '{0, 0, 0, 1, 0, 3, 3, 3, 0, 2, 2, 2, 2, 2, 2, 2};
        logic [15:0] act;
        hit = 0; c = 0; tv = 0;
        if (!iv) return;
        act = ir & ie & {16{g}};
        for (int k = 0; k < 6; k++)
            if (act[io[k]]) begin hit = 1; c = 32'h8000_0000 + io[k]; return; end
        for (int k = 15; k >= 12; k--)
            if (act[k]) begin hit = 1; c = 32'h8000_0000 + k; return; end
        for (int k = 0; k < 16; k++) begin
            if (e[eb[k]] && (bq[k] == 0 || (int'(b) & bq[k]) != 0)) begin
                hit = 1;
                c   = eb[k];
                case (tk[k])
                    0: tv = p;
                    1: tv = ins;
                    2: tv = ma;
                    default: tv = 0;
                endcase
                return;
            end
        end
    endfunction

    task automatic clear_inputs();
        instr_valid = 0; exc = 0; bs = 0; irq = 0; irq_en = 0; gie = 0;
        pc = 0; instr = 0; mem_addr = 0; ready = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Handshake after `delay` idle cycles, then count flush cycles (-1 on timeout).
    task automatic accept(input int delay, output int nflush);
        repeat (delay) step();
        ready = 1;
        step();
        ready = 0;
        nflush = 0;
        while (flush === 1'b1 && nflush < 20) begin
            nflush++;
            step();
        end
        if (nflush >= 20) nflush = -1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({valid, flush, busy} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctrl got v/f/b=%b%b%b want 000", valid, flush, busy);
        end
        n_cmp++;
        if ({cause, tval, epc} !== 96'h0) begin
            n_err++; $display("FAIL reset_rec got cause=%h tval=%h epc=%h want 0", cause, tval, epc);
        end
        rst_n = 1;
        step();
    endtask

    task automatic test_reset_mid_flush();
        exc = 16'h0001; instr_valid = 1; pc = 32'h40;
        step();
        clear_inputs();
        ready = 1;
        step();
        ready = 0;
        n_cmp++;
        if (flush !== 1'b1) begin
            n_err++; $display("FAIL midflush_enter got flush=%b want 1", flush);
        end
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({valid, flush, busy} !== 3'b000 || {cause, tval, epc} !== 96'h0) begin
            n_err++; $display("FAIL midflush_reset got v/f/b=%b%b%b cause=%h tval=%h epc=%h want all 0",
                              valid, flush, busy, cause, tval, epc);
        end
        @(negedge clk);
        rst_n = 1;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL midflush_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_access_fault();
        int nf;
        exc = 16'h0006; instr_valid = 1; pc = 32'h100; instr = 32'hFFFF_FFFF;
        step();
        clear_inputs();
        n_cmp++;
        if (valid !== 1'b1 || cause !== 32'h1 || epc !== 32'h100 || tval !== 32'h100) begin
            n_err++; $display("FAIL access_fault got v=%b cause=%h epc=%h tval=%h want 1/1/100/100",
                              valid, cause, epc, tval);
        end
        accept(0, nf);
    endtask

    task automatic test_hold_and_flush();
        int nf;
        exc = 16'h0030; instr_valid = 1; pc = 32'h204; mem_addr = 32'h2003;
        step();
        clear_inputs();
        n_cmp++;
        if (cause !== 32'h4 || tval !== 32'h2003) begin
            n_err++; $display("FAIL load_misalign got cause=%h tval=%h want 4/2003", cause, tval);
        end
        for (int i = 0; i < 5; i++) begin
            exc = 16'hFFFF; instr_valid = 1; pc = 32'h999;
            step();
            n_cmp++;
            if (valid !== 1'b1 || cause !== 32'h4 || tval !== 32'h2003 || epc !== 32'h204 || flush !== 1'b0) begin
                n_err++; $display("FAIL hold_stable cyc=%0d got v=%b cause=%h tval=%h epc=%h flush=%b want 1/4/2003/204/0",
                                  i, valid, cause, tval, epc, flush);
            end
        end
        clear_inputs();
        accept(0, nf);
        n_cmp++;
        if (nf !== FC || busy !== 1'b0) begin
            n_err++; $display("FAIL flush_len got %0d busy=%b want %0d busy=0", nf, busy, FC);
        end
    endtask

    task automatic test_irq_vs_exc();
        int nf;
        irq = 16'h0880; irq_en = 16'hFFFF; gie = 1; exc = 16'h0004; instr_valid = 1;
        pc = 32'h300; instr = 32'hDEAD_BEEF;
        step();
        n_cmp++;
        if (cause !== 32'h8000_000B || tval !== 32'h0) begin
            n_err++; $display("FAIL irq_wins got cause=%h tval=%h want 8000000b/0", cause, tval);
        end
        clear_inputs();
        accept(0, nf);
        irq = 16'h0880; irq_en = 16'hFFFF; gie = 0; exc = 16'h0004; instr_valid = 1;
        pc = 32'h300; instr = 32'hDEAD_BEEF;
        step();
        clear_inputs();
        n_cmp++;
        if (cause !== 32'h2 || tval !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL gie_off got cause=%h tval=%h want 2/deadbeef", cause, tval);
        end
        accept(1, nf);
    endtask

    task automatic test_breakpoint();
        int nf;
        exc = 16'h0008; bs = 3'b000; instr_valid = 1; pc = 32'h400; mem_addr = 32'h3333;
        step();
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL bp_nosrc got v=%b busy=%b want 0/0", valid, busy);
        end
        bs = 3'b010;
        step();
        clear_inputs();
        n_cmp++;
        if (valid !== 1'b1 || cause !== 32'h3 || tval !== 32'h3333) begin
            n_err++; $display("FAIL watchpoint got v=%b cause=%h tval=%h want 1/3/3333", valid, cause, tval);
        end
        accept(0, nf);
    endtask

    task automatic test_ignore_and_held();
        int n;
        exc = 16'h2000; instr_valid = 1; pc = 32'h500; mem_addr = 32'h55;
        step();
        exc = 16'h0001; pc = 32'h600;
        step();
        step();
        ready = 1; exc = 16'h0002;
        step();
        ready = 0; exc = 16'h0800;
        step();
        clear_inputs();
        n = 0;
        while (flush === 1'b1 && n < 20) begin n++; step(); end
        step();
        n_cmp++;
        if (valid !== 1'b0 || cause !== 32'hD || epc !== 32'h500) begin
            n_err++; $display("FAIL ignore_busy got v=%b cause=%h epc=%h want 0/d/500", valid, cause, epc);
        end
        // held event through REQ and FLUSH captures on the first IDLE cycle
        exc = 16'h0040; instr_valid = 1; pc = 32'h510; mem_addr = 32'h66;
        step();
        exc = 16'h1000; pc = 32'h700;
        ready = 1;
        step();
        ready = 0;
        n = 0;
        while (flush === 1'b1 && n < 20) begin n++; step(); end
        n_cmp++;
        if (valid !== 1'b0 || n !== FC) begin
            n_err++; $display("FAIL held_first_idle got v=%b flushcyc=%0d want 0/%0d", valid, n, FC);
        end
        step();
        n_cmp++;
        if (valid !== 1'b1 || cause !== 32'hC || epc !== 32'h700 || tval !== 32'h700) begin
            n_err++; $display("FAIL held_capture got v=%b cause=%h epc=%h tval=%h want 1/c/700/700",
                              valid, cause, epc, tval);
        end
        clear_inputs();
        accept(0, n);
        irq = 16'h8008; irq_en = 16'hFFFF; gie = 1; instr_valid = 1; pc = 32'h800;
        step();
        clear_inputs();
        n_cmp++;
        if (cause !== 32'h8000_0003) begin
            n_err++; $display("FAIL irq15_vs_3 got cause=%h want 80000003", cause);
        end
        accept(0, n);
    endtask

    task automatic test_random();
        bit          hit;
        logic [31:0] c_exp, t_exp, e_exp;
        logic [31:0] c_last, t_last, e_last;
        int          nf;
        c_last = cause; t_last = tval; e_last = epc;
        for (int it = 0; it < 300; it++) begin
            instr_valid = ($urandom_range(0, 7) != 0);
            exc      = 16'($urandom & $urandom & $urandom);
            bs       = 3'($urandom);
            irq      = 16'($urandom & $urandom & $urandom);
            irq_en   = 16'($urandom);
            gie      = ($urandom_range(0, 3) == 0);
            pc       = $urandom;
            instr    = $urandom;
            mem_addr = $urandom;
            ref_model(instr_valid, exc, bs, irq, irq_en, gie, pc, instr, mem_addr, hit, c_exp, t_exp);
            e_exp = pc;
            step();
            clear_inputs();
            n_cmp++;
            if (hit) begin
                if (valid !== 1'b1 || cause !== c_exp || tval !== t_exp || epc !== e_exp) begin
                    n_err++; $display("FAIL rand_trap it=%0d got v=%b cause=%h tval=%h epc=%h want 1/%h/%h/%h",
                                      it, valid, cause, tval, epc, c_exp, t_exp, e_exp);
                end
                c_last = c_exp; t_last = t_exp; e_last = e_exp;
                accept($urandom_range(0, 3), nf);
                n_cmp++;
                if (nf !== FC || busy !== 1'b0) begin
                    n_err++; $display("FAIL rand_flush it=%0d got %0d busy=%b want %0d/0", it, nf, busy, FC);
                end
            end else begin
                if (valid !== 1'b0 || busy !== 1'b0 || cause !== c_last || tval !== t_last || epc !== e_last) begin
                    n_err++; $display("FAIL rand_idle it=%0d got v=%b busy=%b cause=%h want 0/0/%h",
                                      it, valid, busy, cause, c_last);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_flush();
        test_access_fault();
        test_hold_and_flush();
        test_irq_vs_exc();
        test_breakpoint();
        test_ignore_and_held();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
